// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: one outstanding word request, response strobed by ImemValid.
// The fetch unit is the master; the instruction memory (or its model) is the slave.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
);
    logic              ImemReq;
    logic [PC_W-1:0]   ImemAddr;
    logic              ImemValid;
    logic [INST_W-1:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemValid,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemValid,
        output ImemRdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, fetches one word at a time from a variable-latency
// memory, parks a response in a 1-entry buffer during ID stalls, and squashes on redirects.
module instr_fetch_unit #(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP      = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    RedirectPc,
    instr_fetch_unit_if.master imem,
    output logic               IfIdValid,
    output logic [PC_W-1:0]    IfIdPc,
    output logic [INST_W-1:0]  IfIdInstr,
    output logic [6:0]         Opcode
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [PC_W-1:0]   if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]   buf_pc_q, buf_pc_d;
    logic [INST_W-1:0] buf_instr_q, buf_instr_d;
    logic              loaded;
    logic [PC_W-1:0]   pc_inc;

    assign pc_inc = pc_q + PC_W'(4);

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        loaded      = 1'b0;

        case (state_q)
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (imem.ImemValid) begin
                    if (!Stall) begin
                        loaded     = 1'b1;
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem.ImemRdata;
                        pc_d       = pc_inc;
                        state_d    = S_REQ;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem.ImemRdata;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!Stall) begin
                    loaded     = 1'b1;
                    if_valid_d = 1'b1;
                    if_pc_d    = buf_pc_q;
                    if_instr_d = buf_instr_q;
                    pc_d       = pc_inc;
                    state_d    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (imem.ImemValid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (!loaded && !Stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP;
        end

        // Redirect outranks Stall and any response. The only way to drop the in-flight word
        // is to keep waiting for it in DISCARD; once it has arrived we may fetch again.
        if (Redirect) begin
            pc_d        = {RedirectPc[PC_W-1:2], 2'b00};
            if_valid_d  = 1'b0;
            if_instr_d  = NOP;
            buf_pc_d    = '0;
            buf_instr_d = NOP;
            if ((state_q == S_WAIT || state_q == S_DISCARD) && !imem.ImemValid)
                state_d = S_DISCARD;
            else
                state_d = S_REQ;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= NOP;
            // NOTE: the hold buffer is ordinary flops, not a RAM, so it is reset with the rest.
            buf_pc_q    <= '0;
            buf_instr_q <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem.ImemReq  = (state_q == S_REQ) && rst_n;
    assign imem.ImemAddr = pc_q;
    assign IfIdValid     = if_valid_q;
    assign IfIdPc        = if_pc_q;
    assign IfIdInstr     = if_instr_q;
    assign Opcode        = if_instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory models plus scoreboards of expected fetch addresses and IF/ID loads.
// A second instance with RESET_PC = FFFFFFFC covers PC wrap and reset during an outstanding fetch.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } load_t;

    logic        clk;
    logic        rst0_n, rst1_n;
    logic        Stall, Redirect;
    logic [31:0] RedirectPc;
    logic        stall1, redir1;
    logic [31:0] redir_pc1;

    logic        if_valid0, if_valid1;
    logic [31:0] if_pc0, if_pc1, if_instr0, if_instr1;
    logic [6:0]  opcode0, opcode1;

    instr_fetch_unit_if #(.PC_W(32), .INST_W(32)) imem0 ();
    instr_fetch_unit_if #(.PC_W(32), .INST_W(32)) imem1 ();

    instr_fetch_unit #(.PC_W(32), .INST_W(32), .RESET_PC(32'h0), .NOP(NOP)) dut0 (
        .clk(clk), .rst_n(rst0_n), .Stall(Stall), .Redirect(Redirect), .RedirectPc(RedirectPc),
        .imem(imem0.master), .IfIdValid(if_valid0), .IfIdPc(if_pc0), .IfIdInstr(if_instr0),
        .Opcode(opcode0)
    );

    instr_fetch_unit #(.PC_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFFC), .NOP(NOP)) dut1 (
        .clk(clk), .rst_n(rst1_n), .Stall(stall1), .Redirect(redir1), .RedirectPc(redir_pc1),
        .imem(imem1.master), .IfIdValid(if_valid1), .IfIdPc(if_pc1), .IfIdInstr(if_instr1),
        .Opcode(opcode1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0:   instr_at = 32'h0050_0093;
            32'h4:   instr_at = 32'h0020_81b3;
            32'h8:   instr_at = 32'h0000_a103;
            default: instr_at = {a[24:0], 7'h37};
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: a request seen at a falling edge is answered lat cycles later for one cycle.
    int          lat0 = 1, lat1 = 1;
    int          cnt0 = 0, cnt1 = 0;
    logic [31:0] maddr0, maddr1;

    always begin
        @(negedge clk);
        imem0.ImemValid = 1'b0;
        if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin
                imem0.ImemValid = 1'b1;
                imem0.ImemRdata = instr_at(maddr0);
            end
        end
        if (imem0.ImemReq) begin
            maddr0 = imem0.ImemAddr;
            cnt0   = lat0;
        end
    end

    always begin
        @(negedge clk);
        imem1.ImemValid = 1'b0;
        if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin
                imem1.ImemValid = 1'b1;
                imem1.ImemRdata = instr_at(maddr1);
            end
        end
        if (imem1.ImemReq) begin
            maddr1 = imem1.ImemAddr;
            cnt1   = lat1;
        end
    end

    // Scoreboards for dut0: every request and every new IF/ID load is matched against the queues.
    logic [31:0] exp_addr_q[$];
    load_t       exp_ld_q[$];
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = '0;

    always begin
        @(negedge clk);
        #1;
        if (imem0.ImemReq) begin
            check("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) check("req_addr", 64'(imem0.ImemAddr), 64'(exp_addr_q.pop_front()));
        end
        if (if_valid0 && (!prev_v || if_pc0 != prev_pc)) begin
            check("load_expected", 64'(exp_ld_q.size() != 0), 64'd1);
            if (exp_ld_q.size() != 0) begin
                load_t e;
                e = exp_ld_q.pop_front();
                check("ifid_pc", 64'(if_pc0), 64'(e.pc));
                check("ifid_instr", 64'(if_instr0), 64'(e.instr));
                check("opcode", 64'(opcode0), 64'(e.instr[6:0]));
            end
        end
        prev_v  = if_valid0;
        prev_pc = if_pc0;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_ld(input logic [31:0] pc);
        load_t e;
        e.pc    = pc;
        e.instr = instr_at(pc);
        exp_ld_q.push_back(e);
    endtask

    task automatic reset0();
        rst0_n = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        RedirectPc = '0;
        idle(2);
        check("rst_req", 64'(imem0.ImemReq), 64'd0);
        check("rst_valid", 64'(if_valid0), 64'd0);
        check("rst_ifpc", 64'(if_pc0), 64'd0);
        check("rst_instr", 64'(if_instr0), 64'(NOP));
        check("rst_opcode", 64'(opcode0), 64'h13);
    endtask

    // Release just after a rising edge so the REQ cycle is fully visible, then settle mid-cycle.
    task automatic release0();
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        step();
    endtask

    task automatic release1();
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        step();
    endtask

    task automatic wait_req(input logic [31:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (imem0.ImemReq && imem0.ImemAddr == a) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("wait_req", 64'(found), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        imem0.ImemValid = 1'b0;
        imem0.ImemRdata = '0;
        imem1.ImemValid = 1'b0;
        imem1.ImemRdata = '0;
        rst1_n = 1'b0;
        stall1 = 1'b0;
        redir1 = 1'b0;
        redir_pc1 = '0;

        // Reset, then straight-line fetch with 1-cycle memory.
        reset0();
        lat0 = 1;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        push_ld(32'h0); push_ld(32'h4); push_ld(32'h8);
        release0();
        check("rel_req", 64'(imem0.ImemReq), 64'd1);
        check("rel_addr", 64'(imem0.ImemAddr), 64'd0);
        idle(2);
        check("a_pc0", 64'(if_pc0), 64'h0);
        check("a_v0", 64'(if_valid0), 64'd1);
        step();
        check("a_bubble", 64'(if_valid0), 64'd0);
        step();
        check("a_pc4", 64'(if_pc0), 64'h4);
        wait_req(32'hC);
        Stall = 1'b1;
        idle(4);

        // Stall over the response for address 4: buffered, fetched once, released in order.
        reset0();
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        push_ld(32'h0); push_ld(32'h4);
        release0();
        wait_req(32'h4);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_hold_pc", 64'(if_pc0), 64'h0);
            check("b_hold_v", 64'(if_valid0), 64'd1);
            check("b_noreq", 64'(imem0.ImemReq), 64'd0);
        end
        Stall = 1'b0;
        step();
        check("b_pc4", 64'(if_pc0), 64'h4);
        check("b_req8", 64'(imem0.ImemReq), 64'd1);
        check("b_addr8", 64'(imem0.ImemAddr), 64'h8);
        Stall = 1'b1;
        idle(4);

        // 3-cycle memory, redirect while waiting: stale word dropped, refetch from 40.
        reset0();
        lat0 = 3;
        exp_addr_q = '{32'h0, 32'h40, 32'h44};
        push_ld(32'h40);
        release0();
        step();
        Redirect = 1'b1;
        RedirectPc = 32'h40;
        step();
        Redirect = 1'b0;
        check("c_valid", 64'(if_valid0), 64'd0);
        check("c_instr", 64'(if_instr0), 64'(NOP));
        wait_req(32'h44);
        check("c_pc40", 64'(if_pc0), 64'h40);
        Stall = 1'b1;
        idle(6);

        // Redirect and Stall together with a misaligned jalr target; late response lands in REQ.
        reset0();
        lat0 = 1;
        exp_addr_q = '{32'h0, 32'h4, 32'h100, 32'h104};
        push_ld(32'h0); push_ld(32'h100);
        release0();
        wait_req(32'h4);
        Stall = 1'b1;
        Redirect = 1'b1;
        RedirectPc = 32'h103;
        step();
        Redirect = 1'b0;
        Stall = 1'b0;
        check("d_addr", 64'(imem0.ImemAddr), 64'h100);
        check("d_req", 64'(imem0.ImemReq), 64'd1);
        check("d_instr", 64'(if_instr0), 64'(NOP));
        check("d_valid", 64'(if_valid0), 64'd0);
        check("d_opcode", 64'(opcode0), 64'h13);
        wait_req(32'h104);
        Stall = 1'b1;
        idle(4);

        // Redirect coinciding with a response, then redirect out of HOLD (buffer discarded).
        reset0();
        exp_addr_q = '{32'h0, 32'h200, 32'h204, 32'h300, 32'h304};
        push_ld(32'h200); push_ld(32'h300);
        release0();
        step();
        Redirect = 1'b1;
        RedirectPc = 32'h200;
        step();
        Redirect = 1'b0;
        check("e_drop_v", 64'(if_valid0), 64'd0);
        wait_req(32'h204);
        Stall = 1'b1;
        idle(2);
        Redirect = 1'b1;
        RedirectPc = 32'h300;
        step();
        Redirect = 1'b0;
        Stall = 1'b0;
        check("e_hold_v", 64'(if_valid0), 64'd0);
        check("e_addr300", 64'(imem0.ImemAddr), 64'h300);
        wait_req(32'h304);
        Stall = 1'b1;
        idle(4);

        // Second instance: PC wraps past FFFFFFFC, then reset mid-WAIT with a late response.
        lat1 = 1;
        idle(2);
        release1();
        check("f_addr_rst", 64'(imem1.ImemAddr), 64'hFFFF_FFFC);
        check("f_req_rst", 64'(imem1.ImemReq), 64'd1);
        step();
        lat1 = 2;
        step();
        check("f_wrap_addr", 64'(imem1.ImemAddr), 64'h0);
        check("f_wrap_req", 64'(imem1.ImemReq), 64'd1);
        check("f_pc", 64'(if_pc1), 64'hFFFF_FFFC);
        check("f_instr", 64'(if_instr1), 64'(instr_at(32'hFFFF_FFFC)));
        step();
        rst1_n = 1'b0;
        #1;
        check("f_rst_req", 64'(imem1.ImemReq), 64'd0);
        check("f_rst_v", 64'(if_valid1), 64'd0);
        release1();
        check("f_rel_addr", 64'(imem1.ImemAddr), 64'hFFFF_FFFC);
        step();
        check("f_late_v", 64'(if_valid1), 64'd0);
        step();
        check("f_late_v2", 64'(if_valid1), 64'd0);
        step();
        check("f_refetch_v", 64'(if_valid1), 64'd1);
        check("f_refetch_pc", 64'(if_pc1), 64'hFFFF_FFFC);
        check("f_refetch_addr", 64'(imem1.ImemAddr), 64'h0);

        check("addr_q_left", 64'(exp_addr_q.size()), 64'd0);
        check("ld_q_left", 64'(exp_ld_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
